// File: rtl/uarch_pkg.sv
// Shared micro-architecture types: register file geometry, data word, mode,
// and the operand-fetch sequencer state encoding.
package uarch;

    localparam int NUM_GPREGS = 16;
    localparam int REG_W      = $clog2(NUM_GPREGS);
    localparam int WORD_W     = 32;
    localparam int MODE_W     = 5;

    typedef logic [WORD_W-1:0] word;
    typedef logic [REG_W-1:0]  reg_num;
    typedef logic [MODE_W-1:0] psr_mode;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} reg_fetch_state;

endpackage

// File: rtl/core_reg_fetch.sv
// Operand-fetch sequencer: issues one register-file read per cycle for each
// used source slot, collects the 1-cycle-late data and hands the set downstream.
module core_reg_fetch
    import uarch::*;
#(
    parameter int NUM_OPS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_OPS*REG_W-1:0]  in_rs,
    input  logic [NUM_OPS-1:0]        in_use,
    input  logic [MODE_W-1:0]         in_mode,
    output logic [REG_W-1:0]          rd_r,
    output logic [MODE_W-1:0]         rd_mode,
    input  logic [WORD_W-1:0]         rd_value,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_OPS*WORD_W-1:0] out_ops
);

    localparam int SLOT_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    function automatic logic [SLOT_W-1:0] first_slot(input logic [NUM_OPS-1:0] m);
        first_slot = '0;
        for (int i = NUM_OPS - 1; i >= 0; i--)
            if (m[i]) first_slot = SLOT_W'(i);
    endfunction

    function automatic logic [NUM_OPS-1:0] slot_bit(input logic [SLOT_W-1:0] s);
        slot_bit = NUM_OPS'(1) << s;
    endfunction

    reg_fetch_state                   state;
    logic [NUM_OPS-1:0][REG_W-1:0]    in_rs_a;
    logic [NUM_OPS-1:0][REG_W-1:0]    rs_q;
    logic [NUM_OPS-1:0]               rem_q;
    logic [SLOT_W-1:0]                cur_slot;
    logic [SLOT_W-1:0]                pend_slot;
    logic                             pend_vld;
    logic [SLOT_W-1:0]                in_first;
    logic [SLOT_W-1:0]                rem_first;
    logic [NUM_OPS-1:0][WORD_W-1:0]   ops;
    logic                             accept;

    assign in_rs_a   = in_rs;
    assign in_first  = first_slot(in_use);
    assign rem_first = first_slot(rem_q);
    assign in_ready  = !flush && (state == IDLE || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_ops   = ops;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            ops       <= '0;
            rd_r      <= '0;
            rd_mode   <= '0;
            rs_q      <= '0;
            rem_q     <= '0;
            cur_slot  <= '0;
            pend_slot <= '0;
            pend_vld  <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            pend_vld  <= 1'b0;
        end else if (accept) begin
            rs_q      <= in_rs_a;
            ops       <= '0;
            pend_vld  <= 1'b0;
            out_valid <= 1'b0;
            // An op with no operands passes through DRAIN so every op,
            // empty or not, reports valid k+1 cycles after acceptance.
            if (in_use == '0) begin
                state <= DRAIN;
            end else begin
                state    <= ISSUE;
                rd_r     <= in_rs_a[in_first];
                rd_mode  <= in_mode;
                cur_slot <= in_first;
                rem_q    <= in_use & ~slot_bit(in_first);
            end
        end else begin
            case (state)
                ISSUE: begin
                    if (pend_vld) ops[pend_slot] <= rd_value;
                    pend_vld  <= 1'b1;
                    pend_slot <= cur_slot;
                    if (rem_q != '0) begin
                        rd_r     <= rs_q[rem_first];
                        cur_slot <= rem_first;
                        rem_q    <= rem_q & ~slot_bit(rem_first);
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pend_vld) ops[pend_slot] <= rd_value;
                    pend_vld  <= 1'b0;
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_reg_fetch.sv
// Bench for core_reg_fetch: directed table, flush/reset corner sequences and
// random ops checked against a slot-list model of the operand fetch.
module tb_core_reg_fetch;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [11:0] in_rs;
    logic [2:0]  in_use;
    logic [4:0]  in_mode, rd_mode;
    logic [3:0]  rd_r;
    logic [31:0] rd_value;
    logic [95:0] out_ops;

    int errs = 0;
    int checks = 0;

    core_reg_fetch #(.NUM_OPS(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_use(in_use), .in_mode(in_mode),
        .rd_r(rd_r), .rd_mode(rd_mode), .rd_value(rd_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_ops(out_ops)
    );

    always #5 clk = ~clk;

    // Register file model: register i holds 0x100+i, one cycle read latency.
    always @(posedge clk) rd_value <= 32'h100 + 32'(rd_r);

    typedef struct {
        logic [2:0][3:0] rs;
        logic [2:0]      use_m;
        int              stall;
        logic [95:0]     ops;
        int              lat;
    } vec_t;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] model_ops(input logic [2:0][3:0] rs, input logic [2:0] use_m);
        logic [95:0] v = '0;
        for (int i = 0; i < 3; i++)
            if (use_m[i]) v[i*32 +: 32] = 32'h100 + 32'(rs[i]);
        return v;
    endfunction

    // Presents one op (consuming any finished set), then checks read order,
    // latency, operands and stability under a stall. Returns with the set held.
    task automatic run_op(input logic [2:0][3:0] rs, input logic [2:0] use_m,
                          input logic [4:0] mode, input int stall,
                          input logic [95:0] exp_ops, input int exp_lat);
        logic [3:0] seq[$];
        logic [3:0] prev_rd;
        int n, guard;
        for (int i = 0; i < 3; i++) if (use_m[i]) seq.push_back(rs[i]);
        prev_rd   = rd_r;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_rs     = rs;
        in_use    = use_m;
        in_mode   = mode;
        #1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        chk("accept_wait", 96'(guard < 50), 96'(1));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            if (n < seq.size()) begin
                chk("rd_r_order", 96'(rd_r), 96'(seq[n]));
                chk("rd_mode", 96'(rd_mode), 96'(mode));
            end
            @(posedge clk); #1; n++;
        end
        if (seq.size() == 0) chk("rd_r_hold", 96'(rd_r), 96'(prev_rd));
        chk("latency", 96'(n), 96'(exp_lat));
        chk("ops", out_ops, exp_ops);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_valid", 96'(out_valid), 96'(1));
            chk("stall_ops", out_ops, exp_ops);
            chk("stall_in_ready", 96'(in_ready), 96'(0));
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        #1;
        chk("consume_valid", 96'(out_valid), 96'(0));
        chk("consume_in_ready", 96'(in_ready), 96'(1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        logic [2:0][3:0] rrs;
        logic [2:0] ruse;

        tbl[0] = '{rs: {4'd9, 4'd7, 4'd3},  use_m: 3'b111, stall: 0, ops: {32'h109, 32'h107, 32'h103}, lat: 4};
        tbl[1] = '{rs: {4'd1, 4'd5, 4'd2},  use_m: 3'b101, stall: 1, ops: {32'h101, 32'h0,   32'h102}, lat: 3};
        tbl[2] = '{rs: {4'd15, 4'd14, 4'd13}, use_m: 3'b000, stall: 0, ops: 96'h0,                      lat: 1};
        tbl[3] = '{rs: {4'd12, 4'd11, 4'd10}, use_m: 3'b111, stall: 5, ops: {32'h10c, 32'h10b, 32'h10a}, lat: 4};
        tbl[4] = '{rs: {4'd0, 4'd15, 4'd0}, use_m: 3'b010, stall: 0, ops: {32'h0,   32'h10f, 32'h0},   lat: 2};
        tbl[5] = '{rs: {4'd4, 4'd0, 4'd6},  use_m: 3'b100, stall: 2, ops: {32'h104, 32'h0,   32'h0},   lat: 2};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_rs = '0; in_use = '0; in_mode = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 96'(in_ready), 96'(1));
        chk("rst_out_valid", 96'(out_valid), 96'(0));
        chk("rst_ops", out_ops, 96'h0);
        chk("rst_rd_r", 96'(rd_r), 96'(0));
        chk("rst_rd_mode", 96'(rd_mode), 96'(0));

        // Back-to-back table ops: each new op is accepted on the edge that
        // consumes the previous set.
        for (int i = 0; i < 6; i++)
            run_op(tbl[i].rs, tbl[i].use_m, 5'(i + 3), tbl[i].stall, tbl[i].ops, tbl[i].lat);
        consume();

        // Flush in the second ISSUE cycle; the late capture must be dropped.
        in_valid = 1'b1; in_rs = {4'd3, 4'd2, 4'd1}; in_use = 3'b111; in_mode = 5'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1;
        #1;
        chk("flush_in_ready", 96'(in_ready), 96'(0));
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 96'(out_valid), 96'(0));
        chk("flush_idle_ready", 96'(in_ready), 96'(1));
        repeat (5) @(posedge clk);
        #1;
        chk("flush_stays_idle", 96'(out_valid), 96'(0));
        run_op({4'd6, 4'd5, 4'd0}, 3'b110, 5'd2, 0, {32'h106, 32'h105, 32'h0}, 3);

        // Flush coinciding with an accept from DONE: the op is not taken.
        out_ready = 1'b1; in_valid = 1'b1; flush = 1'b1;
        in_rs = {4'd7, 4'd7, 4'd7}; in_use = 3'b111;
        #1;
        chk("flush_accept_ready", 96'(in_ready), 96'(0));
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_accept_valid", 96'(out_valid), 96'(0));
        repeat (6) @(posedge clk);
        #1;
        chk("flush_accept_not_taken", 96'(out_valid), 96'(0));

        // Reset mid-ISSUE after one operand has already been captured.
        in_valid = 1'b1; in_rs = {4'd10, 4'd9, 4'd8}; in_use = 3'b111; in_mode = 5'd17;
        #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("mid_rst_out_valid", 96'(out_valid), 96'(0));
        chk("mid_rst_in_ready", 96'(in_ready), 96'(1));
        chk("mid_rst_ops", out_ops, 96'h0);
        chk("mid_rst_rd_r", 96'(rd_r), 96'(0));
        chk("mid_rst_rd_mode", 96'(rd_mode), 96'(0));

        // Random ops against the slot-list model, with random stalls and gaps.
        for (int i = 0; i < 40; i++) begin
            rrs  = 12'($urandom);
            ruse = 3'($urandom_range(0, 7));
            run_op(rrs, ruse, 5'($urandom), int'($urandom_range(0, 3)),
                   model_ops(rrs, ruse), $countones(ruse) + 1);
            if ($urandom_range(0, 3) == 0) consume();
        end
        consume();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
